// File: rtl/midi_pkg.sv
// Shared definitions for the MIDI voice front-end: status nibbles, parser states
// and power-on values of the voice parameter registers.
package midi_pkg;

    localparam logic [3:0] NOTE_OFF   = 4'h8;
    localparam logic [3:0] NOTE_ON    = 4'h9;
    localparam logic [3:0] CC         = 4'hB;
    localparam logic [3:0] PROG_CHG   = 4'hC;
    localparam logic [3:0] CHAN_PRESS = 4'hD;
    localparam logic [3:0] BEND       = 4'hE;

    localparam logic [6:0] CC_ALL_NOTES_OFF = 7'd123;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_D1,
        WAIT_D2
    } parser_state_t;

    localparam logic [6:0]  RST_COARSE = 7'd64;
    localparam logic [6:0]  RST_FINE   = 7'd64;
    localparam logic [6:0]  RST_WAVE   = 7'd0;
    localparam logic [6:0]  RST_SHAPE  = 7'd0;
    localparam logic [6:0]  RST_LEVEL  = 7'd100;
    localparam logic [6:0]  RST_FM     = 7'd0;
    localparam logic [13:0] RST_BEND   = 14'h2000;

    // Program change and channel pressure carry one data byte, all others two.
    function automatic logic single_data(input logic [3:0] kind);
        return (kind == PROG_CHG) || (kind == CHAN_PRESS);
    endfunction

endpackage

// File: rtl/midi_voice_ctrl_if.sv
// Byte input and voice/parameter outputs of the MIDI voice controller.
interface midi_voice_if;

    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        note_on;
    logic        note_off;
    logic        gate;
    logic [6:0]  note_freq;
    logic [6:0]  velocity;
    logic [13:0] pitchbend;
    logic [6:0]  COARSE_TUNE_CC;
    logic [6:0]  FINE_TUNE_CC;
    logic [6:0]  WAVE_CC;
    logic [6:0]  SHAPE_CC;
    logic [6:0]  LEVEL_CC;
    logic [6:0]  FM;

    modport master (
        output rx_data, rx_valid,
        input  note_on, note_off, gate, note_freq, velocity, pitchbend,
        input  COARSE_TUNE_CC, FINE_TUNE_CC, WAVE_CC, SHAPE_CC, LEVEL_CC, FM
    );

    modport slave (
        input  rx_data, rx_valid,
        output note_on, note_off, gate, note_freq, velocity, pitchbend,
        output COARSE_TUNE_CC, FINE_TUNE_CC, WAVE_CC, SHAPE_CC, LEVEL_CC, FM
    );

endinterface

// File: rtl/midi_msg_parser.sv
// Running-status MIDI parser; emits a combinational one-cycle msg_valid for each
// completed channel message addressed to MIDI_CH.
module midi_msg_parser
    import midi_pkg::*;
#(
    parameter int MIDI_CH = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       msg_valid,
    output logic [3:0] msg_kind,
    output logic [6:0] msg_d1,
    output logic [6:0] msg_d2
);

    localparam logic [3:0] CH = 4'(MIDI_CH);

    parser_state_t state, state_n;
    logic [7:0]    status, status_n;
    logic [6:0]    d1, d1_n;
    logic          chan_ok;

    assign chan_ok = (status[3:0] == CH);

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            status <= 8'h00;
        end else begin
            state  <= state_n;
            status <= status_n;
        end
    end

    always_ff @(posedge clk) begin
        d1 <= d1_n;
    end

    always_comb begin
        state_n   = state;
        status_n  = status;
        d1_n      = d1;
        msg_valid = 1'b0;
        msg_kind  = status[7:4];
        msg_d1    = d1;
        msg_d2    = rx_data[6:0];
        if (rx_valid) begin
            if (rx_data >= 8'hF8) begin
                // Real-time bytes are transparent, even inside a message.
            end else if (rx_data >= 8'hF0) begin
                state_n  = IDLE;
                status_n = 8'h00;
            end else if (rx_data[7]) begin
                state_n  = WAIT_D1;
                status_n = rx_data;
            end else begin
                case (state)
                    WAIT_D1: begin
                        if (single_data(status[7:4])) begin
                            msg_valid = chan_ok;
                            msg_d1    = rx_data[6:0];
                            msg_d2    = 7'd0;
                        end else begin
                            d1_n    = rx_data[6:0];
                            state_n = WAIT_D2;
                        end
                    end
                    WAIT_D2: begin
                        msg_valid = chan_ok;
                        state_n   = WAIT_D1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: rtl/midi_voice_ctrl.sv
// Monophonic voice control: last-note-wins gating, pitch bend and CC parameter
// registers driven from parsed MIDI messages.
module midi_voice_ctrl
    import midi_pkg::*;
#(
    parameter int MIDI_CH   = 0,
    parameter int CC_COARSE = 20,
    parameter int CC_FINE   = 21,
    parameter int CC_WAVE   = 22,
    parameter int CC_SHAPE  = 23,
    parameter int CC_LEVEL  = 7,
    parameter int CC_FM     = 24
) (
    input  logic         clk_top,
    input  logic         rst_top,
    midi_voice_if.slave  bus
);

    logic       msg_valid;
    logic [3:0] msg_kind;
    logic [6:0] msg_d1, msg_d2;

    logic        note_on_p0, note_off_p0, gate_p0;
    logic [6:0]  note_freq_p0, velocity_p0;
    logic [13:0] bend_p0;
    logic [6:0]  coarse_p0, fine_p0, wave_p0, shape_p0, level_p0, fm_p0;
    logic        release_hit;

    midi_msg_parser #(.MIDI_CH(MIDI_CH)) u_parser (
        .clk       (clk_top),
        .rst       (rst_top),
        .rx_data   (bus.rx_data),
        .rx_valid  (bus.rx_valid),
        .msg_valid (msg_valid),
        .msg_kind  (msg_kind),
        .msg_d1    (msg_d1),
        .msg_d2    (msg_d2)
    );

    assign release_hit = gate_p0 && (msg_d1 == note_freq_p0);

    // Message decode stage: outputs register on the edge that samples the last data byte.
    always_ff @(posedge clk_top) begin
        if (rst_top) begin
            note_on_p0   <= 1'b0;
            note_off_p0  <= 1'b0;
            gate_p0      <= 1'b0;
            note_freq_p0 <= 7'd0;
            velocity_p0  <= 7'd0;
            bend_p0      <= RST_BEND;
            coarse_p0    <= RST_COARSE;
            fine_p0      <= RST_FINE;
            wave_p0      <= RST_WAVE;
            shape_p0     <= RST_SHAPE;
            level_p0     <= RST_LEVEL;
            fm_p0        <= RST_FM;
        end else begin
            note_on_p0  <= 1'b0;
            note_off_p0 <= 1'b0;
            if (msg_valid) begin
                case (msg_kind)
                    NOTE_ON: begin
                        if (msg_d2 != 7'd0) begin
                            note_freq_p0 <= msg_d1;
                            velocity_p0  <= msg_d2;
                            gate_p0      <= 1'b1;
                            note_on_p0   <= 1'b1;
                        end else if (release_hit) begin
                            gate_p0     <= 1'b0;
                            note_off_p0 <= 1'b1;
                        end
                    end
                    NOTE_OFF: begin
                        if (release_hit) begin
                            gate_p0     <= 1'b0;
                            note_off_p0 <= 1'b1;
                        end
                    end
                    CC: begin
                        if (msg_d1 == 7'(CC_COARSE)) coarse_p0 <= msg_d2;
                        if (msg_d1 == 7'(CC_FINE))   fine_p0   <= msg_d2;
                        if (msg_d1 == 7'(CC_WAVE))   wave_p0   <= msg_d2;
                        if (msg_d1 == 7'(CC_SHAPE))  shape_p0  <= msg_d2;
                        if (msg_d1 == 7'(CC_LEVEL))  level_p0  <= msg_d2;
                        if (msg_d1 == 7'(CC_FM))     fm_p0     <= msg_d2;
                        if ((msg_d1 == CC_ALL_NOTES_OFF) && gate_p0) begin
                            gate_p0     <= 1'b0;
                            note_off_p0 <= 1'b1;
                        end
                    end
                    BEND: bend_p0 <= {msg_d2, msg_d1};
                    default: ;
                endcase
            end
        end
    end

    assign bus.note_on        = note_on_p0;
    assign bus.note_off       = note_off_p0;
    assign bus.gate           = gate_p0;
    assign bus.note_freq      = note_freq_p0;
    assign bus.velocity       = velocity_p0;
    assign bus.pitchbend      = bend_p0;
    assign bus.COARSE_TUNE_CC = coarse_p0;
    assign bus.FINE_TUNE_CC   = fine_p0;
    assign bus.WAVE_CC        = wave_p0;
    assign bus.SHAPE_CC       = shape_p0;
    assign bus.LEVEL_CC       = level_p0;
    assign bus.FM             = fm_p0;

endmodule

// File: tb/tb_midi_voice_ctrl.sv
// Scoreboard bench for midi_voice_ctrl: a message-level reference model predicts the
// full output state after every cycle; a monitor compares it against the DUT.
module tb_midi_voice_ctrl;

    logic clk_top = 1'b0;
    logic rst_top;
    always #5 clk_top = ~clk_top;

    midi_voice_if bus ();

    midi_voice_ctrl #(.MIDI_CH(0)) dut (
        .clk_top (clk_top),
        .rst_top (rst_top),
        .bus     (bus.slave)
    );

    typedef struct packed {
        logic        on;
        logic        off;
        logic        gate;
        logic [6:0]  nf;
        logic [6:0]  vel;
        logic [13:0] pb;
        logic [6:0]  co;
        logic [6:0]  fi;
        logic [6:0]  wa;
        logic [6:0]  sh;
        logic [6:0]  le;
        logic [6:0]  fm;
    } snap_t;

    typedef struct packed {
        int unsigned cyc;
        snap_t       s;
    } exp_t;

    localparam snap_t RST_SNAP = '{on: 1'b0, off: 1'b0, gate: 1'b0, nf: 7'd0, vel: 7'd0,
                                   pb: 14'h2000, co: 7'd64, fi: 7'd64, wa: 7'd0,
                                   sh: 7'd0, le: 7'd100, fm: 7'd0};

    exp_t        q[$];
    int unsigned cyc = 0;
    int          checks = 0;
    int          passed = 0;

    snap_t       m;
    logic [7:0]  rs;
    logic [6:0]  pend[$];

    exp_t        mon_e;
    snap_t       mon_g;

    always @(posedge clk_top) cyc <= cyc + 1;

    // Monitor: compare every predicted state whose cycle tag has come due.
    always @(negedge clk_top) begin
        while (q.size() > 0 && q[0].cyc == cyc) begin
            mon_e = q.pop_front();
            mon_g = '{on: bus.note_on, off: bus.note_off, gate: bus.gate,
                      nf: bus.note_freq, vel: bus.velocity, pb: bus.pitchbend,
                      co: bus.COARSE_TUNE_CC, fi: bus.FINE_TUNE_CC, wa: bus.WAVE_CC,
                      sh: bus.SHAPE_CC, le: bus.LEVEL_CC, fm: bus.FM};
            checks++;
            if (mon_g === mon_e.s) passed++;
            else $display("FAIL voice_state cyc=%0d got=%h required=%h", cyc, mon_g, mon_e.s);
        end
    end

    task automatic release_note(input logic [6:0] n);
        if (m.gate && n == m.nf) begin
            m.gate = 1'b0;
            m.off  = 1'b1;
        end
    endtask

    task automatic apply_msg(input logic [7:0] st, input logic [6:0] a, input logic [6:0] d);
        if (st[3:0] != 4'd0) return;
        case (st[7:4])
            4'h9: begin
                if (d != 0) begin
                    m.nf = a; m.vel = d; m.gate = 1'b1; m.on = 1'b1;
                end else release_note(a);
            end
            4'h8: release_note(a);
            4'hB: begin
                case (a)
                    7'd20: m.co = d;
                    7'd21: m.fi = d;
                    7'd22: m.wa = d;
                    7'd23: m.sh = d;
                    7'd7:  m.le = d;
                    7'd24: m.fm = d;
                    7'd123: if (m.gate) begin m.gate = 1'b0; m.off = 1'b1; end
                    default: ;
                endcase
            end
            4'hE: m.pb = {d, a};
            default: ;
        endcase
    endtask

    task automatic model_byte(input logic [7:0] b);
        int need;
        logic [6:0] second;
        if (b >= 8'hF8) return;
        if (b >= 8'hF0) begin
            rs = 8'h00; pend.delete();
        end else if (b[7]) begin
            rs = b; pend.delete();
        end else if (rs != 8'h00) begin
            pend.push_back(b[6:0]);
            need = (rs[7:4] == 4'hC || rs[7:4] == 4'hD) ? 1 : 2;
            if (pend.size() == need) begin
                second = 7'd0;
                if (need == 2) second = pend[1];
                apply_msg(rs, pend[0], second);
                pend.delete();
            end
        end
    endtask

    task automatic step(input bit r, input bit v, input logic [7:0] b);
        exp_t e;
        @(negedge clk_top);
        rst_top      = r;
        bus.rx_valid = v;
        bus.rx_data  = b;
        m.on  = 1'b0;
        m.off = 1'b0;
        if (r) begin
            m = RST_SNAP; rs = 8'h00; pend.delete();
        end else if (v) begin
            model_byte(b);
        end
        e.cyc = cyc + 1;
        e.s   = m;
        q.push_back(e);
    endtask

    task automatic send(input logic [7:0] b);
        step(1'b0, 1'b1, b);
    endtask

    task automatic send_list(input logic [7:0] bytes[$]);
        foreach (bytes[i]) send(bytes[i]);
        step(1'b0, 1'b0, 8'h00);
    endtask

    logic [7:0] pool[12] = '{8'h3C, 8'h3E, 8'h40, 8'h00, 8'h7F, 8'd20, 8'd21, 8'd22,
                             8'd23, 8'd7, 8'd24, 8'd123};
    logic [3:0] kinds[7] = '{4'h8, 4'h9, 4'hA, 4'hB, 4'hC, 4'hD, 4'hE};

    initial begin
        rst_top      = 1'b1;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        m  = RST_SNAP;
        rs = 8'h00;

        step(1'b1, 1'b0, 8'h00);
        step(1'b1, 1'b0, 8'h00);
        step(1'b0, 1'b0, 8'h00);

        send_list('{8'h90, 8'h3C, 8'h64, 8'h3E, 8'h50});
        send_list('{8'h80, 8'h3C, 8'h00, 8'h90, 8'h3E, 8'h00});
        send_list('{8'hB0, 8'h14, 8'h10, 8'hB0, 8'h07, 8'h7F, 8'hB1, 8'h14, 8'h00});
        send_list('{8'hE0, 8'hF8, 8'h00, 8'h40, 8'hE0, 8'h7F, 8'h7F});
        send(8'h90);
        send(8'h3C);
        step(1'b1, 1'b0, 8'h00);
        send_list('{8'h64, 8'hF0, 8'h3C, 8'h64, 8'hF7});
        send_list('{8'h90, 8'h40, 8'h50, 8'hB0, 8'h7B, 8'h00});

        for (int i = 0; i < 4000; i++) begin
            int r;
            logic [7:0] b;
            r = $urandom_range(0, 99);
            if (r < 2) step(1'b1, 1'b0, 8'h00);
            else if (r < 12) step(1'b0, 1'b0, 8'($urandom));
            else if (r < 16) send(8'hF8 + 8'($urandom_range(0, 7)));
            else if (r < 19) send(8'hF0 + 8'($urandom_range(0, 7)));
            else if (r < 38) begin
                b = {kinds[$urandom_range(0, 6)], 4'h0};
                if ($urandom_range(0, 9) < 3) b[3:0] = 4'($urandom_range(0, 15));
                send(b);
            end else begin
                if ($urandom_range(0, 3) == 0) b = 8'($urandom_range(0, 127));
                else b = pool[$urandom_range(0, 11)];
                send(b);
            end
        end

        step(1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge clk_top);
        #1;
        if (q.size() != 0) begin
            checks++;
            $display("FAIL drain pending=%0d required=0", q.size());
        end
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/midi_voice_ctrl.md
# midi_voice_ctrl

Front-end control stage for the monophonic VCO voice. It parses a MIDI byte stream from the UART receiver and drives the VCO's note and parameter inputs: note_on/note_off pulses, held note number and velocity, 14-bit pitch bend, and the six 7-bit CC registers (coarse tune, fine tune, wave, shape, level, FM). It filters one MIDI channel, supports running status, and applies last-note-wins monophonic gating.

## Interface
- MIDI_CH, 0: MIDI channel to accept, 0..15; messages on other channels are parsed and discarded.
- CC_COARSE, 20 / CC_FINE, 21 / CC_WAVE, 22 / CC_SHAPE, 23 / CC_LEVEL, 7 / CC_FM, 24: controller numbers mapped to the parameter registers.
- clk_top  in  1  system clock; the only clock.
- rst_top  in  1  synchronous, active-high reset.
- rx_data  in  8  received MIDI byte; valid only when rx_valid=1.
- rx_valid  in  1  one-cycle strobe, at most one byte per cycle.
- note_on  out  1  one-cycle pulse on an accepted note-on.
- note_off  out  1  one-cycle pulse when the sounding note is released.
- gate  out  1  high while a note sounds.
- note_freq  out  7  current note number, held.
- velocity  out  7  velocity of the current note, held.
- pitchbend  out  14  {MSB[6:0], LSB[6:0]}.
- COARSE_TUNE_CC, FINE_TUNE_CC, WAVE_CC, SHAPE_CC, LEVEL_CC, FM  out  7 each  parameter registers.

## Operation
- Reset values: note_on=0, note_off=0, gate=0, note_freq=0, velocity=0, pitchbend=14'h2000, COARSE_TUNE_CC=64, FINE_TUNE_CC=64, WAVE_CC=0, SHAPE_CC=0, LEVEL_CC=100, FM=0. The parser is in IDLE with running status cleared.
- Parser FSM states:
  - IDLE: no running status.
  - WAIT_D1: status held, expecting the first data byte.
  - WAIT_D2: first data byte latched, expecting the second.
- Byte classes:
  - 0xF8-0xFF (real-time): ignored entirely. State and running status are unchanged, including mid-message.
  - 0xF0-0xF7 (system common/SysEx): clears running status and goes to IDLE. Data bytes then ignored until the next channel status byte.
  - 0x80-0xEF (channel status): latches status and goes to WAIT_D1. Any partial message is abandoned.
  - 0x00-0x7F (data): consumed per the current state. Ignored in IDLE.
- Accepted message types: 0x8n, 0x9n, 0xBn, 0xEn (all two data bytes).
- Other channel types: 0xAn and 0xDn are parsed (2 and 1 data bytes respectively) and discarded; 0xCn is parsed (1 data byte) and discarded.
- Message completion:
  - A message completes when its last data byte arrives; the FSM then returns to WAIT_D1, keeping status (running status).
  - A message whose channel ≠ MIDI_CH completes but has no effect.
- Note-on with velocity > 0:
  - note_freq←d1, velocity←d2, gate←1, note_on pulse.
  - This also applies while gate=1 (retrigger, last note wins); no note_off pulse is issued in that case.
- Note-off (0x8n, or 0x9n with velocity 0):
  - When gate=1 and d1==note_freq: gate←0 and note_off pulse. note_freq and velocity are held.
  - Otherwise: no effect.
- Control change:
  - d1 matching one of the CC_* parameters loads d2 into that register.
  - d1=123 (all notes off) with gate=1: gate←0 and note_off pulse.
  - Other CC numbers: ignored.
- Pitch bend: pitchbend←{d2,d1}, loaded atomically on the second data byte.

## Timing
- Latency: every output updates on the clock edge where the final data byte is sampled with rx_valid=1. Outputs are visible the following cycle; all outputs are registered.
- note_on and note_off are exactly one cycle wide. They never assert in the same cycle.
- Back-to-back bytes on consecutive cycles are supported at full rate.
- rst_top mid-message: the partial message is discarded and all outputs return to their reset values on the next edge.
- Data byte in WAIT_D2 after a status byte arrived in between: treated as the first data byte of the new status.

## Structure
- Shared package midi_pkg holds:
  - status nibble constants (NOTE_OFF=4'h8, NOTE_ON=4'h9, CC=4'hB, BEND=4'hE);
  - CC_ALL_NOTES_OFF=123;
  - the parser state enum;
  - reset constants for the parameter registers.
- Sub-module midi_msg_parser: byte classification, running-status FSM, and channel match. It emits a one-cycle msg_valid with status, d1 and d2.
- Top level: voice/gate logic and the CC register file.

## Test plan
- 0x90,0x3C,0x64 -> note_on pulse, note_freq=60, velocity=100, gate=1; then 0x3E,0x50 (running status) -> second note_on pulse, note_freq=62, velocity=80, no note_off pulse.
- With gate=1 on note 62: 0x80,0x3C,0x00 -> no change; then 0x90,0x3E,0x00 -> note_off pulse, gate=0, note_freq still 62.
- 0xB0,0x14,0x10 then 0xB0,0x07,0x7F -> COARSE_TUNE_CC=16, LEVEL_CC=127; 0xB1,0x14,0x00 -> COARSE_TUNE_CC stays 16.
- 0xE0,0xF8,0x00,0x40 -> pitchbend=14'h2000 (0xF8 clock byte ignored); then 0xE0,0x7F,0x7F -> pitchbend=14'h3FFF.
- 0x90,0x3C, rst_top one cycle, 0x64 -> no note_on, all outputs at reset values; 0xF0,0x3C,0x64,0xF7 -> no output change.
- With gate=1: 0xB0,0x7B,0x00 -> note_off pulse, gate=0.
